alu_multicycle: RTL and testbench

Parametrised, registered successor to the combinational datapath ALU. It accepts one operation per valid/ready handshake, computes ops 0–6 in a single cycle, and computes MUL (op 7) iteratively over WIDTH cycles. It holds each result plus flags until the consumer takes it. It sits between the decode/operand-fetch stage and writeback, and lets a multi-cycle EX stage stall cleanly.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_mul_iter.sv | 64 ++++++
 rtl/alu_multicycle.sv | 141 ++++++++++++++
 tb/tb_alu_multicycle.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes and FSM state encoding for the multicycle ALU
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_SLL = 3'd4;
   localparam logic [2:0] OP_SRL = 3'd5;
   localparam logic [2:0] OP_SLT = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - shift-add multiplier, one multiplier bit per cycle
module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] acc_step;

   always_comb begin
      acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (start) begin
         mcand_d  = a;
         mplier_d = b;
         acc_d    = '0;
         cnt_d    = CW'(WIDTH - 1);
         busy_d   = 1'b1;
      end else if (busy_q) begin
         acc_d    = acc_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - CW'(1);
         if (cnt_q == '0) busy_d = 1'b0;
      end
   end

   // done fires on the final step so the caller can capture acc_step on the same edge
   assign done    = busy_q && (cnt_q == '0);
   assign product = acc_step;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - registered ALU with valid/ready handshake and iterative MUL
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter bit MUL_ENABLE = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       select,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zeroflag,
   output logic             carry,
   output logic             overflow
);
   localparam int SHW = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic             accept, is_mul, start_mul, mul_done;
   logic [WIDTH-1:0] mul_product;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v;
   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] out_q, out_d;
   logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;

   assign accept    = in_valid && in_ready;
   assign is_mul    = MUL_ENABLE && (select == OP_MUL);
   assign start_mul = accept && is_mul;

   generate
      if (MUL_ENABLE) begin : g_mul
         alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (start_mul),
            .a       (a),
            .b       (b),
            .done    (mul_done),
            .product (mul_product)
         );
      end else begin : g_no_mul
         assign mul_done    = 1'b0;
         assign mul_product = '0;
      end
   endgenerate

   always_comb begin
      sum     = {1'b0, a} + {1'b0, b};
      diff    = {1'b0, a} - {1'b0, b};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (select)
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = diff[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_SLL:  alu_res = a << b[SHW-1:0];
         OP_SRL:  alu_res = a >> b[SHW-1:0];
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: alu_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = is_mul ? ST_MUL : ST_DONE;
         ST_MUL:  if (mul_done) state_d = ST_DONE;
         ST_DONE: begin
            if (accept)         state_d = is_mul ? ST_MUL : ST_DONE;
            else if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
      out_valid = (state_q == ST_DONE);
   end

   // result registers only move on a single-cycle accept or the final MUL step
   always_comb begin
      out_d   = out_q;
      zero_d  = zero_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      if (accept && !is_mul) begin
         out_d   = alu_res;
         zero_d  = (alu_res == '0);
         carry_d = alu_c;
         ovf_d   = alu_v;
      end else if ((state_q == ST_MUL) && mul_done) begin
         out_d   = mul_product;
         zero_d  = (mul_product == '0);
         carry_d = 1'b0;
         ovf_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         zero_q  <= 1'b1;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         out_q   <= out_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out      = out_q;
   assign zeroflag = zero_q;
   assign carry    = carry_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - randomized and directed bench against an arithmetic reference model
module tb_alu_multicycle;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [2:0]   select = '0;
   logic         in_ready, out_valid, zeroflag, carry, overflow;
   logic [W-1:0] out;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_multicycle #(.WIDTH(W), .MUL_ENABLE(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .select    (select),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .zeroflag  (zeroflag),
      .carry     (carry),
      .overflow  (overflow)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // returns {overflow, carry, result}
   function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
      longint unsigned ux, uy, wide;
      longint          sx, sy, s;
      logic [31:0]     r;
      logic            c, v;
      ux = x; uy = y;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      r = 0; c = 0; v = 0;
      case (op)
         3'd0: begin
            wide = ux + uy; r = wide[31:0]; c = (wide > 64'hFFFF_FFFF);
            s = sx + sy; v = (s != longint'(int'(s)));
         end
         3'd1: begin
            r = x - y; c = (x < y);
            s = sx - sy; v = (s != longint'(int'(s)));
         end
         3'd2: r = x & y;
         3'd3: r = x | y;
         3'd4: r = x << (y % 32);
         3'd5: r = x >> (y % 32);
         3'd6: r = (sx < sy) ? 32'd1 : 32'd0;
         default: begin wide = ux * uy; r = wide[31:0]; end
      endcase
      return {v, c, r};
   endfunction

   task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op,
                         input int hold, input string tag);
      logic [33:0] e;
      logic [31:0] held;
      int cyc, bad;
      e = model(x, y, op);
      @(negedge clk);
      check({tag, "_in_ready"}, in_ready, 1);
      a = x; b = y; select = op; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; select = 3'($urandom);
      if (hold > 0) out_ready = 1'b0;
      cyc = 0; bad = 0;
      while (!out_valid && cyc < 200) begin
         if (in_ready) bad++;
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_latency"}, cyc, (op == 3'd7) ? W : 0);
      if (op == 3'd7) check({tag, "_busy_ready"}, bad, 0);
      check({tag, "_out"}, out, e[31:0]);
      check({tag, "_zero"}, zeroflag, e[31:0] == 0);
      check({tag, "_carry"}, carry, e[32]);
      check({tag, "_ovf"}, overflow, e[33]);
      if (hold > 0) begin
         held = out; bad = 0;
         repeat (hold) begin
            @(posedge clk); #1;
            if (out !== held || !out_valid || in_ready) bad++;
         end
         check({tag, "_hold"}, bad, 0);
         out_ready = 1'b1;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_out", out, 0);
      check("rst_zero", zeroflag, 1);
      check("rst_carry", carry, 0);
      check("rst_ovf", overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", in_ready, 1);

      run_op(32'd1, 32'd1, 3'd0, 0, "add_1_1");
      run_op(32'd1, 32'd1, 3'd1, 0, "sub_1_1");
      run_op(32'h7FFF_FFFF, 32'd1, 3'd0, 0, "add_ovf");
      run_op(32'hFFFF_FFFF, 32'd1, 3'd0, 0, "add_carry");
      run_op(32'd0, 32'd1, 3'd1, 0, "sub_borrow");
      run_op(32'd1, 32'd1, 3'd2, 0, "and");
      run_op(32'd1, 32'd1, 3'd3, 0, "or");
      run_op(32'd1, 32'd1, 3'd4, 0, "sll");
      run_op(32'd1, 32'd1, 3'd5, 0, "srl");
      run_op(32'd1, 32'd1, 3'd6, 0, "slt_1_1");
      run_op(32'hFFFF_FFFF, 32'd1, 3'd6, 0, "slt_neg");
      run_op(32'd1, 32'd33, 3'd4, 0, "sll_mask");
      run_op(32'h0001_0001, 32'h0001_0001, 3'd7, 10, "mul_hold");
      run_op(32'd3, 32'd4, 3'd0, 4, "add_hold");

      @(negedge clk);
      in_valid = 1'b1; select = 3'd0; a = 32'd1; b = 32'd1;
      @(posedge clk); #1;
      check("b2b_valid0", out_valid, 1);
      check("b2b_out0", out, 2);
      a = 32'd2; b = 32'd2;
      @(posedge clk); #1;
      check("b2b_out1", out, 4);
      a = 32'd3; b = 32'd3;
      @(posedge clk); #1;
      check("b2b_out2", out, 6);
      check("b2b_valid2", out_valid, 1);
      in_valid = 1'b0;

      @(negedge clk);
      in_valid = 1'b1; select = 3'd7; a = 32'h1234_5678; b = 32'h9ABC_DEF1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("mulrst_pre_valid", out_valid, 0);
      rst_n = 1'b0;
      #1;
      check("mulrst_valid", out_valid, 0);
      check("mulrst_out", out, 0);
      check("mulrst_zero", zeroflag, 1);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(32'd5, 32'd5, 3'd0, 0, "post_rst_add");
      repeat (W + 4) @(posedge clk);
      #1;
      check("post_rst_stale", out, 10);

      repeat (40) begin
         run_op($urandom, $urandom, 3'($urandom), ($urandom_range(0, 3) == 0) ? 3 : 0, "rnd");
      end
      run_op($urandom, 32'd0, 3'd7, 0, "mul_zero");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
